// File: rtl/imm_table_pkg.sv
// rtl/imm_table_pkg.sv - shared types, default sizes and parity helper for the immediate table
package imm_table_pkg;

    typedef enum logic [0:0] {INIT, IDLE} imm_tbl_state_e;

    localparam int IMM_DEFAULT_WIDTH = 8;
    localparam int IMM_DEFAULT_DEPTH = 32;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic imm_parity(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/imm_table_rd_port.sv
// rtl/imm_table_rd_port.sv - one registered read port with write-first bypass and range check
module imm_table_rd_port
    import imm_table_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = IMM_DEFAULT_WIDTH,
    parameter int DEPTH           = IMM_DEFAULT_DEPTH,
    parameter int IDX_W           = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_accept,
    input  logic [IDX_W-1:0]           rd_index,
    input  logic [DATA_PATH_WIDTH-1:0] entry_data,
    input  logic                       wr_fire,
    input  logic [IDX_W-1:0]           wr_index,
    input  logic [DATA_PATH_WIDTH-1:0] wr_data,
    output logic [DATA_PATH_WIDTH-1:0] rd_data,
    output logic                       rd_valid
`ifdef IMM_TABLE_PARITY_EN
    ,
    input  logic                       entry_par,
    output logic                       parity_err
`endif
);

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

    logic in_range;
    logic bypass;

    assign in_range = {1'b0, rd_index} < DEPTH_L;
    assign bypass   = wr_fire && (wr_index == rd_index);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
`ifdef IMM_TABLE_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_accept;
`ifdef IMM_TABLE_PARITY_EN
            parity_err <= rd_accept && in_range && !bypass &&
                          (imm_parity(64'(entry_data)) != entry_par);
`endif
            if (rd_accept) begin
                if (!in_range) begin
                    rd_data <= '0;
                end else if (bypass) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= entry_data;
                end
            end
        end
    end

endmodule

// File: rtl/imm_table.sv
// rtl/imm_table.sv - writable DEPTH-entry immediate table with init engine and NUM_RD read ports
// Optional per-entry parity with parity_err output under IMM_TABLE_PARITY_EN.
module imm_table
    import imm_table_pkg::*;
#(
    parameter int                         DATA_PATH_WIDTH = IMM_DEFAULT_WIDTH,
    parameter int                         DEPTH           = IMM_DEFAULT_DEPTH,
    parameter int                         NUM_RD          = 2,
    parameter logic [DATA_PATH_WIDTH-1:0] INIT_VALUE      = '0,
    localparam int                        IDX_W           = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_RD-1:0]                 rd_en,
    input  logic [NUM_RD*IDX_W-1:0]           rd_index,
    output logic [NUM_RD*DATA_PATH_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]                 rd_valid,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [IDX_W-1:0]                  wr_index,
    input  logic [DATA_PATH_WIDTH-1:0]        wr_data,
    input  logic                              init_req,
    output logic                              busy
`ifdef IMM_TABLE_PARITY_EN
    ,
    output logic [NUM_RD-1:0]                 parity_err
`endif
);

    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    imm_tbl_state_e             state;
    logic [IDX_W-1:0]           init_cnt;
    logic [DATA_PATH_WIDTH-1:0] mem [DEPTH];
`ifdef IMM_TABLE_PARITY_EN
    logic                       par_mem [DEPTH];
`endif

    logic wr_fire;
    logic wr_in_range;

    // init_req blocks both the write and any read in the cycle it is sampled.
    assign wr_ready    = (state == IDLE) && !init_req;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = {1'b0, wr_index} < DEPTH_L;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == LAST_IDX) begin
                        state    <= IDLE;
                        init_cnt <= '0;
                        busy     <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (init_req) begin
                        state    <= INIT;
                        init_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; the init engine rewrites every entry instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                mem[init_cnt] <= INIT_VALUE;
`ifdef IMM_TABLE_PARITY_EN
                par_mem[init_cnt] <= imm_parity(64'(INIT_VALUE));
`endif
            end else if (wr_fire && wr_in_range) begin
                mem[wr_index] <= wr_data;
`ifdef IMM_TABLE_PARITY_EN
                par_mem[wr_index] <= imm_parity(64'(wr_data));
`endif
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [IDX_W-1:0] idx;
        assign idx = rd_index[p*IDX_W +: IDX_W];

        imm_table_rd_port #(
            .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
            .DEPTH           (DEPTH),
            .IDX_W           (IDX_W)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_accept  (rd_en[p] && wr_ready),
            .rd_index   (idx),
            .entry_data (mem[idx]),
            .wr_fire    (wr_fire),
            .wr_index   (wr_index),
            .wr_data    (wr_data),
            .rd_data    (rd_data[p*DATA_PATH_WIDTH +: DATA_PATH_WIDTH]),
            .rd_valid   (rd_valid[p])
`ifdef IMM_TABLE_PARITY_EN
            ,
            .entry_par  (par_mem[idx]),
            .parity_err (parity_err[p])
`endif
        );
    end

endmodule

// File: tb/tb_imm_table.sv
// tb/tb_imm_table.sv - scoreboard bench for imm_table with directed and random traffic
module tb_imm_table;

    localparam int W     = 8;
    localparam int DEPTH = 20;
    localparam int NRD   = 2;
    localparam int IW    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD-1:0]    rd_en;
    logic [NRD*IW-1:0] rd_index;
    logic [NRD*W-1:0]  rd_data;
    logic [NRD-1:0]    rd_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [IW-1:0]     wr_index;
    logic [W-1:0]      wr_data;
    logic              init_req;
    logic              busy;
`ifdef IMM_TABLE_PARITY_EN
    logic [NRD-1:0]    parity_err;
`endif

    always #5 clk = ~clk;

    imm_table #(
        .DATA_PATH_WIDTH (W),
        .DEPTH           (DEPTH),
        .NUM_RD          (NRD),
        .INIT_VALUE      (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .init_req   (init_req),
        .busy       (busy)
`ifdef IMM_TABLE_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    typedef struct packed {
        logic [NRD-1:0]   v;
        logic [NRD*W-1:0] d;
    } exp_t;

    exp_t         q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] mdl [DEPTH];
    logic [W-1:0] last [NRD];
    int           init_left = 0;
    bit           known = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic idle();
        rd_en    = '0;
        wr_valid = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic rd(input int p, input int idx);
        rd_en[p]              = 1'b1;
        rd_index[p*IW +: IW]  = IW'(idx);
    endtask

    task automatic wr(input int idx, input int d);
        wr_valid = 1'b1;
        wr_index = IW'(idx);
        wr_data  = W'(d);
    endtask

    // Reference model: the table is a plain array; entering init clears it
    // and opens a DEPTH-cycle window where reads and writes are refused.
    task automatic step();
        exp_t e;
        #1;
        e.v = '0;
        if (!rst_n) begin
            foreach (mdl[i]) mdl[i] = '0;
            foreach (last[i]) last[i] = '0;
            init_left = DEPTH;
            known     = 1'b1;
            e.d       = '0;
        end else begin
            if (known) begin
                check("busy", 32'(busy), 32'(init_left > 0));
                check("wr_ready", 32'(wr_ready), 32'(init_left == 0 && !init_req));
            end
            if (init_left > 0) begin
                init_left--;
            end else if (init_req) begin
                foreach (mdl[i]) mdl[i] = '0;
                init_left = DEPTH;
            end else begin
                for (int p = 0; p < NRD; p++) begin
                    if (rd_en[p]) begin
                        int idx;
                        idx = int'(rd_index[p*IW +: IW]);
                        if (idx >= DEPTH)                              last[p] = '0;
                        else if (wr_valid && int'(wr_index) == idx)    last[p] = wr_data;
                        else                                           last[p] = mdl[idx];
                        e.v[p] = 1'b1;
                    end
                end
                if (wr_valid && int'(wr_index) < DEPTH) mdl[wr_index] = wr_data;
            end
            for (int p = 0; p < NRD; p++) e.d[p*W +: W] = last[p];
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rd_valid", 32'(rd_valid), 32'(e.v));
            check("rd_data", 32'(rd_data), 32'(e.d));
        end
    end

    initial begin
        rd_index = '0;
        wr_index = '0;
        wr_data  = '0;
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (DEPTH + 2) step();

        rd(0, 5); step(); idle(); step();

        wr(3, 'hA5); step(); idle();
        rd(0, 3); rd(1, 3); step(); idle(); step();

        wr(7, 'h3C); rd(1, 7); rd(0, 3); step(); idle(); step();

        wr(25, 'h77); step(); idle();
        rd(0, 25); rd(1, 25); step(); idle();
        wr(19, 'h11); step(); idle();
        rd(1, 19); step(); idle(); step();

        init_req = 1'b1; wr(2, 'hFF); rd(0, 2); step(); idle();
        repeat (DEPTH) step();
        rd(0, 2); rd(1, 19); step(); idle(); step();

        init_req = 1'b1; step(); idle();
        repeat (10) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (DEPTH + 1) step();

`ifdef IMM_TABLE_PARITY_EN
        wr(4, 'h5A); step(); idle();
        dut.par_mem[4] = ~dut.par_mem[4];
        rd(0, 4); step(); idle();
        check("parity_err", 32'(parity_err), 32'h1);
        step();
`endif

        for (int c = 0; c < 800; c++) begin
            idle();
            rst_n    = ($urandom_range(0, 299) != 0);
            init_req = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 1) != 0) wr(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)));
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(0, 2) != 0) rd(p, int'($urandom_range(0, 24)));
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (3) step();
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
